// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the iterative ALU.
// Imported by alu_iter and alu_muldiv_iter.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_REM   = 4'd14,
    OP_REMU  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider.
// One step per cycle for WIDTH cycles; y is the sign-fixed result.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] y
);

  localparam int CW = $clog2(WIDTH) + 1;

  alu_op_e          op_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic             sa_q;
  logic             sb_q;
  logic             dz_q;

  logic             sgn;
  logic             sa;
  logic             sb;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   diff;

  assign sgn  = (op == OP_DIV) || (op == OP_REM);
  assign sa   = sgn & a[WIDTH-1];
  assign sb   = sgn & b[WIDTH-1];
  assign msum = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
  assign rs   = {hi, lo[WIDTH-1]};
  assign diff = rs - {1'b0, d};
  assign last = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      op_q <= op;
      sa_q <= sa;
      sb_q <= sb;
      dz_q <= (b == '0);
      hi   <= '0;
      lo   <= sa ? -a : a;
      d    <= sb ? -b : b;
      cnt  <= CW'(WIDTH);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (op_q >= OP_DIV) begin
        // restoring step: keep the trial remainder only if it stayed >= 0
        if (!diff[WIDTH]) begin
          hi <= diff[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= rs[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi <= msum[WIDTH:1];
        lo <= {msum[0], lo[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    y = '0;
    case (op_q)
      OP_MUL:   y = lo;
      OP_MULHU: y = hi;
      OP_DIV,
      OP_DIVU:  y = dz_q ? '1 : ((sa_q ^ sb_q) ? -lo : lo);
      OP_REM,
      OP_REMU:  y = sa_q ? -hi : hi;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Datapath ALU: single-cycle ops plus iterative mul/div.
// Registered result, start/busy/done handshake.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);

  state_e           state;
  state_e           nxt;
  alu_op_e          op;
  logic             md_op;
  logic             accept;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] sc_y;
  logic [WIDTH-1:0] md_y;
  logic             md_last;

  assign op     = alu_op_e'(ctrl);
  assign md_op  = (ENABLE_MULDIV != 0) && (op >= OP_MUL);
  assign accept = start && (state == S_IDLE);
  assign shamt  = b[SW-1:0];

  always_comb begin
    sc_y = '0;
    case (op)
      OP_ADD:  sc_y = a + b;
      OP_SUB:  sc_y = a - b;
      OP_AND:  sc_y = a & b;
      OP_OR:   sc_y = a | b;
      OP_XOR:  sc_y = a ^ b;
      OP_SLT:  sc_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_y = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  sc_y = a << shamt;
      OP_SRL:  sc_y = a >> shamt;
      OP_SRA:  sc_y = $signed(a) >>> shamt;
      default: sc_y = '0;
    endcase
  end

  generate
    if (ENABLE_MULDIV != 0) begin : g_md
      alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk   (clk),
        .reset (reset),
        .start (accept && md_op),
        .op    (op),
        .a     (a),
        .b     (b),
        .last  (md_last),
        .y     (md_y)
      );
    end else begin : g_nomd
      assign md_y    = '0;
      assign md_last = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (accept && md_op) nxt = S_RUN;
      S_RUN:   if (md_last) nxt = S_FIX;
      S_FIX:   nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN) || (state == S_FIX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y    <= '0;
      zero <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && !md_op) begin
        y    <= sc_y;
        zero <= (sc_y == '0);
        done <= 1'b1;
      end else if (state == S_FIX) begin
        y    <= md_y;
        zero <= (md_y == '0);
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: vector table, mul/div corner sequences,
// and a 16-bit build without mul/div, all via a result scoreboard.
module tb_alu_iter;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        s32, busy32, done32, z32;
  logic [31:0] a32, b32, y32;
  logic [3:0]  c32;
  logic        s16, busy16, done16, z16;
  logic [15:0] a16, b16, y16;
  logic [3:0]  c16;

  alu_iter #(.WIDTH(32), .ENABLE_MULDIV(1)) dut32 (
    .clk(clk), .reset(reset), .start(s32), .a(a32), .b(b32),
    .ctrl(c32), .busy(busy32), .done(done32), .y(y32), .zero(z32)
  );

  alu_iter #(.WIDTH(16), .ENABLE_MULDIV(0)) dut16 (
    .clk(clk), .reset(reset), .start(s16), .a(a16), .b(b16),
    .ctrl(c16), .busy(busy16), .done(done16), .y(y16), .zero(z16)
  );

  typedef struct {
    logic [31:0] y;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  exp_t q32[$];
  exp_t q16[$];
  vec_t v[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endfunction

  function automatic logic [15:0] m16(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    logic [3:0] sh;
    sh = b[3:0];
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd6: return (a < b) ? 16'd1 : 16'd0;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return $signed(a) >>> sh;
      default: return 16'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done32) begin
      if (q32.size() == 0) begin
        chk("spurious_done32", {31'b0, done32}, 32'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("y32", y32, e.y);
        chk("zero32", {31'b0, z32}, {31'b0, (e.y == 32'd0)});
        chk("lat32", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) begin
        chk("spurious_done16", {31'b0, done16}, 32'd0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("y16", {16'b0, y16}, e.y);
        chk("zero16", {31'b0, z16}, {31'b0, (e.y == 32'd0)});
        chk("lat16", cyc, e.cyc);
      end
    end
  end

  task automatic drive32(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] y, int lat);
    @(negedge clk);
    s32 = 1'b1; c32 = op; a32 = a; b32 = b;
    q32.push_back('{y, cyc + lat});
    @(negedge clk);
    s32 = 1'b0;
  endtask

  task automatic drive16(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    @(negedge clk);
    s16 = 1'b1; c16 = op; a16 = a; b16 = b;
    q16.push_back('{{16'b0, m16(op, a, b)}, cyc + 1});
  endtask

  task automatic wait32();
    for (int i = 0; i < 60 && q32.size() != 0; i++) @(negedge clk);
    chk("timeout32", q32.size(), 32'd0);
    q32.delete();
  endtask

  task automatic wait16();
    for (int i = 0; i < 10 && q16.size() != 0; i++) @(negedge clk);
    chk("timeout16", q16.size(), 32'd0);
    q16.delete();
  endtask

  initial begin
    int t0;
    int nd;
    reset = 1'b1;
    s32 = 1'b0; a32 = '0; b32 = '0; c32 = '0;
    s16 = 1'b0; a16 = '0; b16 = '0; c16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_y32", y32, 32'd0);
    chk("rst_zero32", {31'b0, z32}, 32'd0);
    chk("rst_done32", {31'b0, done32}, 32'd0);
    chk("rst_busy32", {31'b0, busy32}, 32'd0);
    chk("rst_y16", {16'b0, y16}, 32'd0);
    reset = 1'b0;

    v.push_back('{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    v.push_back('{4'd9,  32'h80000000, 32'h00000024, 32'hF8000000});
    v.push_back('{4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000001});
    v.push_back('{4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    v.push_back('{4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF});
    v.push_back('{4'd2,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000});
    v.push_back('{4'd3,  32'hF0000000, 32'h0000000F, 32'hF000000F});
    v.push_back('{4'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555});
    v.push_back('{4'd7,  32'h00000001, 32'h0000003F, 32'h80000000});
    v.push_back('{4'd8,  32'h80000000, 32'h00000021, 32'h40000000});
    v.push_back('{4'd10, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB});
    v.push_back('{4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    v.push_back('{4'd11, 32'h00010000, 32'h00010000, 32'h00000001});
    v.push_back('{4'd12, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD});
    v.push_back('{4'd14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF});
    v.push_back('{4'd13, 32'h00000009, 32'h00000000, 32'hFFFFFFFF});
    v.push_back('{4'd15, 32'h00000009, 32'h00000000, 32'h00000009});
    v.push_back('{4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    v.push_back('{4'd14, 32'h80000000, 32'hFFFFFFFF, 32'h00000000});
    v.push_back('{4'd12, 32'h00000009, 32'h00000000, 32'hFFFFFFFF});
    v.push_back('{4'd14, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9});
    v.push_back('{4'd13, 32'h00000064, 32'h00000007, 32'h0000000E});
    v.push_back('{4'd15, 32'h00000064, 32'h00000007, 32'h00000002});
    v.push_back('{4'd12, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2});

    foreach (v[i]) begin
      drive32(v[i].op, v[i].a, v[i].b, v[i].y, (v[i].op >= 4'd10) ? 34 : 1);
      if (v[i].op < 4'd10) chk("busy_single", {31'b0, busy32}, 32'd0);
      wait32();
    end

    // MUL with an ignored second start while busy
    @(negedge clk);
    s32 = 1'b1; c32 = 4'd10; a32 = 32'd7; b32 = 32'hFFFFFFFD;
    q32.push_back('{32'hFFFFFFEB, cyc + 34});
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) s32 = 1'b0;
      chk("busy_mul", {31'b0, busy32}, {31'b0, (k <= 33)});
      if (k == 5) begin
        s32 = 1'b1; c32 = 4'd10; a32 = 32'd3; b32 = 32'd3;
      end
      if (k == 6) s32 = 1'b0;
    end
    wait32();
    repeat (40) @(negedge clk);

    // reset aborts an op in flight
    @(negedge clk);
    s32 = 1'b1; c32 = 4'd10; a32 = 32'd5; b32 = 32'd6;
    t0 = cyc;
    @(negedge clk);
    s32 = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'b0, busy32}, 32'd0);
    chk("abort_y", y32, 32'd0);
    chk("abort_zero", {31'b0, z32}, 32'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) nd++;
    end
    chk("abort_no_done", nd, 32'd0);

    // 16-bit build without mul/div
    drive16(4'd10, 16'd3, 16'd5);
    @(negedge clk);
    s16 = 1'b0;
    wait16();
    for (int i = 0; i < 60; i++) begin
      drive16(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
    end
    @(negedge clk);
    s16 = 1'b0;
    wait16();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
